// File: rtl/drive_sequencer.sv
// Supervisory sequencer for the wheel-speed datapath: slew-limited base_rpm,
// start/run/stop/fault state machine, PID gating and per-wheel stall detection.
module drive_sequencer #(
    parameter int unsigned RPM_RESOLUTION = 16,
    parameter int unsigned PWM_RESOLUTION = 16,
    parameter int unsigned RAMP_STEP      = 5,
    parameter int unsigned MAX_RPM        = 200,
    parameter int unsigned STALL_DUTY     = 32768,
    parameter int unsigned STALL_RPM      = 5,
    parameter int unsigned STALL_TICKS    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      fault_clear,
    input  logic [RPM_RESOLUTION-1:0] target_rpm,
    input  logic [RPM_RESOLUTION-1:0] rpm_meas_l,
    input  logic [RPM_RESOLUTION-1:0] rpm_meas_r,
    input  logic [PWM_RESOLUTION-1:0] duty_cycle_l,
    input  logic [PWM_RESOLUTION-1:0] duty_cycle_r,
    output logic [RPM_RESOLUTION-1:0] base_rpm,
    output logic                      drive_enable,
    output logic                      pid_clear,
    output logic                      stall_fault,
    output logic [2:0]                state
);

    localparam int unsigned XW = RPM_RESOLUTION + 1;
    localparam int unsigned CW = $clog2(STALL_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RUN       = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_l;
    logic [CW-1:0]             cnt_r;
    logic [RPM_RESOLUTION-1:0] tgt;
    logic [XW-1:0]             base_x;
    logic [XW-1:0]             tgt_x;
    logic [XW-1:0]             step_x;
    logic [XW-1:0]             up_sum;
    logic [RPM_RESOLUTION-1:0] up_next;
    logic [RPM_RESOLUTION-1:0] run_next;
    logic [RPM_RESOLUTION-1:0] down_next;
    logic                      cond_l;
    logic                      cond_r;
    logic [CW-1:0]             cnt_l_next;
    logic [CW-1:0]             cnt_r_next;
    logic                      stall_trig;

    assign state = state_q;

    // Goal clamp and slew arithmetic, one bit wider so nothing wraps
    assign tgt    = (target_rpm > RPM_RESOLUTION'(MAX_RPM)) ? RPM_RESOLUTION'(MAX_RPM) : target_rpm;
    assign base_x = XW'(base_rpm);
    assign tgt_x  = XW'(tgt);
    assign step_x = XW'(RAMP_STEP);
    assign up_sum = base_x + step_x;

    assign up_next   = (up_sum >= tgt_x) ? tgt : up_sum[RPM_RESOLUTION-1:0];
    assign down_next = (base_x <= step_x) ? '0 : RPM_RESOLUTION'(base_x - step_x);

    always_comb begin
        run_next = base_rpm;
        if (base_x < tgt_x) begin
            run_next = up_next;
        end else if (base_x > tgt_x) begin
            run_next = (base_x <= tgt_x + step_x) ? tgt : RPM_RESOLUTION'(base_x - step_x);
        end
    end

    // A wheel is stalled when driven hard but barely turning
    assign cond_l     = (duty_cycle_l >= PWM_RESOLUTION'(STALL_DUTY)) && (rpm_meas_l < RPM_RESOLUTION'(STALL_RPM));
    assign cond_r     = (duty_cycle_r >= PWM_RESOLUTION'(STALL_DUTY)) && (rpm_meas_r < RPM_RESOLUTION'(STALL_RPM));
    assign cnt_l_next = !cond_l ? '0 : (cnt_l == CW'(STALL_TICKS)) ? cnt_l : cnt_l + CW'(1);
    assign cnt_r_next = !cond_r ? '0 : (cnt_r == CW'(STALL_TICKS)) ? cnt_r : cnt_r + CW'(1);
    assign stall_trig = tick && (state_q == S_RUN) &&
                        ((cond_l && (cnt_l == CW'(STALL_TICKS - 1))) ||
                         (cond_r && (cnt_r == CW'(STALL_TICKS - 1))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_rpm     <= '0;
            drive_enable <= 1'b0;
            pid_clear    <= 1'b0;
            stall_fault  <= 1'b0;
            cnt_l        <= '0;
            cnt_r        <= '0;
        end else begin
            pid_clear <= 1'b0;
            if (state_q != S_RUN) begin
                cnt_l <= '0;
                cnt_r <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (start && (tgt != '0)) begin
                        state_q      <= S_RAMP_UP;
                        drive_enable <= 1'b1;
                        pid_clear    <= 1'b1;
                    end
                end
                S_RAMP_UP: begin
                    if (stop) begin
                        state_q <= S_RAMP_DOWN;
                    end else if (tick) begin
                        base_rpm <= up_next;
                        if (up_sum >= tgt_x) begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (stall_trig) begin
                        state_q      <= S_FAULT;
                        stall_fault  <= 1'b1;
                        base_rpm     <= '0;
                        drive_enable <= 1'b0;
                        pid_clear    <= 1'b1;
                        cnt_l        <= '0;
                        cnt_r        <= '0;
                    end else if (stop || (tick && (tgt == '0))) begin
                        state_q <= S_RAMP_DOWN;
                        cnt_l   <= '0;
                        cnt_r   <= '0;
                    end else if (tick) begin
                        base_rpm <= run_next;
                        cnt_l    <= cnt_l_next;
                        cnt_r    <= cnt_r_next;
                    end
                end
                S_RAMP_DOWN: begin
                    if (start && !stop) begin
                        state_q <= S_RAMP_UP;
                    end else if (tick) begin
                        base_rpm <= down_next;
                        if (down_next == '0) begin
                            state_q      <= S_IDLE;
                            drive_enable <= 1'b0;
                        end
                    end
                end
                S_FAULT: begin
                    if (fault_clear) begin
                        state_q     <= S_IDLE;
                        stall_fault <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    drive_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
